// File: rtl/usb_pkg.sv
// usb_pkg: shared types and constants for the USB full-speed transmit path.
//   tx_packet_t  : request codes from the protocol controller
//   tx_state_t   : packetizer FSM states
//   PID_*        : 4-bit packet identifiers
//   SYNC/CRC16   : framing and CRC constants
//   LINE_*       : {dp, dm} line states
//   helpers      : PID byte builder, serial CRC16 step, NRZI encoder
package usb_pkg;

  typedef enum logic [2:0] {
    TX_NONE  = 3'd0,
    TX_DATA0 = 3'd1,
    TX_ACK   = 3'd2,
    TX_NAK   = 3'd3,
    TX_STALL = 3'd4
  } tx_packet_t;

  // ST_LOAD is the one-cycle gap between acceptance and the first SYNC bit.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SYNC    = 3'd2,
    ST_PID     = 3'd3,
    ST_DATA    = 3'd4,
    ST_CRC     = 3'd5,
    ST_EOP_SE0 = 3'd6,
    ST_EOP_J   = 3'd7
  } tx_state_t;

  localparam logic [3:0]  PID_DATA0    = 4'b0011;
  localparam logic [3:0]  PID_ACK      = 4'b0010;
  localparam logic [3:0]  PID_NAK      = 4'b1010;
  localparam logic [3:0]  PID_STALL    = 4'b1110;
  localparam logic [7:0]  SYNC_PATTERN = 8'h80;
  localparam logic [15:0] CRC16_POLY   = 16'h8005;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;
  localparam logic [1:0]  LINE_J       = 2'b10;
  localparam logic [1:0]  LINE_K       = 2'b01;
  localparam logic [1:0]  LINE_SE0     = 2'b00;

  // PID byte as sent on the wire: check nibble in the upper half.
  function automatic logic [7:0] pid_byte(input logic [2:0] code);
    logic [3:0] pid;
    case (code)
      TX_DATA0: pid = PID_DATA0;
      TX_ACK:   pid = PID_ACK;
      TX_NAK:   pid = PID_NAK;
      TX_STALL: pid = PID_STALL;
      default:  pid = 4'b0000;
    endcase
    return {~pid, pid};
  endfunction

  // One serial LFSR step; data enters LSB first, feedback taken from bit 15.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

  // NRZI: a 0 swaps J and K, a 1 holds the line.
  function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic data_bit);
    return data_bit ? line : {line[0], line[1]};
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// usb_crc16: serial CRC16 (poly 0x8005) over payload bits.
//   clk, n_rst : clock, synchronous active-low reset (register -> 16'hFFFF)
//   clear      : reload the init value (asserted at SYNC start)
//   shift_en   : absorb din this cycle
//   din        : payload data bit, LSB first
//   crc_out    : raw register; the packetizer sends its complement
module usb_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        shift_en,
  input  logic        din,
  output logic [15:0] crc_out
);

  logic [15:0] crc_r;

  // CRC register: reset/clear to init, otherwise step once per payload bit.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      crc_r <= CRC16_INIT;
    end else if (clear) begin
      crc_r <= CRC16_INIT;
    end else if (shift_en) begin
      crc_r <= crc16_step(crc_r, din);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc_out = crc_r;

endmodule

// File: rtl/usb_tx_packetizer.sv
// usb_tx_packetizer: builds SYNC/PID/DATA/CRC16, bit-stuffs, NRZI-encodes
// and drives D+/D- ending with EOP.
//   clk, n_rst         : clock, synchronous active-low reset
//   tx_packet          : request code, sampled only in IDLE
//   buffer_occupancy   : bytes in the TX buffer (clamped to MAX_PAYLOAD)
//   tx_packet_data     : buffer head byte, captured on the pop edge
//   get_tx_packet_data : one-cycle pop strobe per payload byte
//   dp_out, dm_out     : line outputs
//   tx_transfer_active : high from first SYNC bit through end of EOP
//   tx_error           : one-cycle pulse on an illegal request code
module usb_tx_packetizer
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int MAX_PAYLOAD  = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic       dp_out,
  output logic       dm_out,
  output logic       tx_transfer_active,
  output logic       tx_error
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [6:0]       MAX_CNT  = 7'(MAX_PAYLOAD);

  tx_state_t        state_r, state_d_s, adv_state_s;
  logic [CNT_W-1:0] clk_cnt_r;
  logic [3:0]       bit_cnt_r, adv_bit_cnt_s;
  logic [2:0]       ones_cnt_r;
  logic             stuff_r;
  logic             is_data_r;
  logic [7:0]       pid_byte_r;
  logic [6:0]       byte_cnt_r;
  logic [7:0]       shift_r;
  logic [1:0]       line_r;
  logic             active_r, get_r, err_r;
  logic [15:0]      crc_s;
  logic             req_valid_s, req_illegal_s;
  logic             bit_step_s, stuff_due_s, load_s, nxt_bit_s, crc_shift_s;

  assign req_valid_s   = (tx_packet >= 3'd1) && (tx_packet <= 3'd4);
  assign req_illegal_s = (tx_packet >= 3'd5);
  // Boundary of a line bit period while a packet is on the wire.
  assign bit_step_s    = (state_r != ST_IDLE) && (state_r != ST_LOAD) && (clk_cnt_r == CNT_LAST);
  // Six ones are on the line and no stuff bit has followed yet.
  assign stuff_due_s   = !stuff_r && (ones_cnt_r == 3'd6);
  // The next line bit is bit 0 of a fresh payload byte.
  assign load_s        = (state_r != ST_IDLE) && !stuff_due_s &&
                         (adv_state_s == ST_DATA) && (adv_bit_cnt_s == 4'd0);
  assign crc_shift_s   = bit_step_s && !stuff_due_s && (adv_state_s == ST_DATA);

  // Next data bit position: where the bit stream goes after the current bit.
  always_comb begin
    adv_state_s   = state_r;
    adv_bit_cnt_s = bit_cnt_r + 4'd1;
    case (state_r)
      ST_LOAD: begin
        adv_state_s   = ST_SYNC;
        adv_bit_cnt_s = 4'd0;
      end
      ST_SYNC, ST_PID, ST_DATA: begin
        if (bit_cnt_r == 4'd7) begin
          adv_bit_cnt_s = 4'd0;
          if (state_r == ST_SYNC)       adv_state_s = ST_PID;
          else if (!is_data_r)          adv_state_s = ST_EOP_SE0;
          else if (byte_cnt_r != 7'd0)  adv_state_s = ST_DATA;
          else                          adv_state_s = ST_CRC;
        end else begin
          adv_state_s = state_r;
        end
      end
      ST_CRC: begin
        if (bit_cnt_r == 4'd15) begin
          adv_state_s   = ST_EOP_SE0;
          adv_bit_cnt_s = 4'd0;
        end else begin
          adv_state_s = ST_CRC;
        end
      end
      ST_EOP_SE0: begin
        if (bit_cnt_r == 4'd1) begin
          adv_state_s   = ST_EOP_J;
          adv_bit_cnt_s = 4'd0;
        end else begin
          adv_state_s = ST_EOP_SE0;
        end
      end
      default: begin
        adv_state_s   = ST_IDLE;
        adv_bit_cnt_s = 4'd0;
      end
    endcase
  end

  // Value of the next data bit; a new payload byte is taken straight from the buffer.
  always_comb begin
    nxt_bit_s = 1'b0;
    case (adv_state_s)
      ST_SYNC: nxt_bit_s = SYNC_PATTERN[adv_bit_cnt_s[2:0]];
      ST_PID:  nxt_bit_s = pid_byte_r[adv_bit_cnt_s[2:0]];
      ST_DATA: nxt_bit_s = (adv_bit_cnt_s == 4'd0) ? tx_packet_data[0] : shift_r[adv_bit_cnt_s[2:0]];
      ST_CRC:  nxt_bit_s = ~crc_s[4'd15 - adv_bit_cnt_s];
      default: nxt_bit_s = 1'b0;
    endcase
  end

  // FSM next state: stuff bits hold the state for one extra bit period.
  always_comb begin
    state_d_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid_s) state_d_s = ST_LOAD;
        else             state_d_s = ST_IDLE;
      end
      ST_LOAD: state_d_s = ST_SYNC;
      default: begin
        if (bit_step_s && !stuff_due_s) state_d_s = adv_state_s;
        else                            state_d_s = state_r;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!n_rst) state_r <= ST_IDLE;
    else        state_r <= state_d_s;
  end

  // Datapath: bit timing, stuffing, NRZI line, byte fetch and status outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      clk_cnt_r  <= '0;
      bit_cnt_r  <= 4'd0;
      ones_cnt_r <= 3'd0;
      stuff_r    <= 1'b0;
      is_data_r  <= 1'b0;
      pid_byte_r <= 8'h00;
      byte_cnt_r <= 7'd0;
      shift_r    <= 8'h00;
      line_r     <= LINE_J;
      active_r   <= 1'b0;
      get_r      <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      get_r <= 1'b0;
      err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          clk_cnt_r <= '0;
          line_r    <= LINE_J;
          active_r  <= 1'b0;
          if (req_valid_s) begin
            pid_byte_r <= pid_byte(tx_packet);
            is_data_r  <= (tx_packet == TX_DATA0);
            byte_cnt_r <= (tx_packet != TX_DATA0) ? 7'd0 :
                          (buffer_occupancy > MAX_CNT) ? MAX_CNT : buffer_occupancy;
          end else begin
            err_r <= req_illegal_s;
          end
        end
        ST_LOAD: begin
          // First SYNC bit goes on the line; ones counting restarts here.
          active_r   <= 1'b1;
          clk_cnt_r  <= '0;
          bit_cnt_r  <= 4'd0;
          stuff_r    <= 1'b0;
          ones_cnt_r <= {2'b00, nxt_bit_s};
          line_r     <= nrzi_next(LINE_J, nxt_bit_s);
        end
        default: begin
          if (clk_cnt_r == CNT_LAST) begin
            clk_cnt_r <= '0;
            if (stuff_due_s) begin
              stuff_r    <= 1'b1;
              ones_cnt_r <= 3'd0;
              line_r     <= nrzi_next(line_r, 1'b0);
            end else begin
              stuff_r   <= 1'b0;
              bit_cnt_r <= adv_bit_cnt_s;
              case (adv_state_s)
                ST_EOP_SE0: begin
                  line_r     <= LINE_SE0;
                  ones_cnt_r <= 3'd0;
                end
                ST_EOP_J: begin
                  line_r     <= LINE_J;
                  ones_cnt_r <= 3'd0;
                end
                ST_IDLE: begin
                  line_r     <= LINE_J;
                  ones_cnt_r <= 3'd0;
                  active_r   <= 1'b0;
                end
                default: begin
                  line_r     <= nrzi_next(line_r, nxt_bit_s);
                  ones_cnt_r <= nxt_bit_s ? (ones_cnt_r + 3'd1) : 3'd0;
                end
              endcase
              if (load_s) begin
                shift_r    <= tx_packet_data;
                byte_cnt_r <= byte_cnt_r - 7'd1;
              end else begin
                shift_r <= shift_r;
              end
            end
          end else begin
            clk_cnt_r <= clk_cnt_r + 1'b1;
            // Strobe lands in the last cycle of the period so the pop edge is the load edge.
            get_r <= (clk_cnt_r == CNT_PRE) && load_s;
          end
        end
      endcase
    end
  end

  usb_crc16 u_crc16 (
    .clk      (clk),
    .n_rst    (n_rst),
    .clear    (state_r == ST_LOAD),
    .shift_en (crc_shift_s),
    .din      (nxt_bit_s),
    .crc_out  (crc_s)
  );

  assign dp_out             = line_r[1];
  assign dm_out             = line_r[0];
  assign tx_transfer_active = active_r;
  assign get_tx_packet_data = get_r;
  assign tx_error           = err_r;

endmodule

// File: tb/tb_usb_tx_packetizer.sv
// tb_usb_tx_packetizer: directed and randomized packets compared cycle by
// cycle against a line-level reference built from the packet contents.
module tb_usb_tx_packetizer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [2:0] tx_packet;
  logic [6:0] buffer_occupancy;
  logic [7:0] tx_packet_data;
  logic       get_tx_packet_data;
  logic       dp_out, dm_out, tx_transfer_active, tx_error;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:1023];
  int         rd_ptr = 0;
  logic [1:0] exp_q [$];

  usb_tx_packetizer #(.CLKS_PER_BIT(4), .MAX_PAYLOAD(64)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_packet          (tx_packet),
    .buffer_occupancy   (buffer_occupancy),
    .tx_packet_data     (tx_packet_data),
    .get_tx_packet_data (get_tx_packet_data),
    .dp_out             (dp_out),
    .dm_out             (dm_out),
    .tx_transfer_active (tx_transfer_active),
    .tx_error           (tx_error)
  );

  always #5 clk = ~clk;

  // TX buffer model: head byte presented combinationally, popped on strobe.
  assign tx_packet_data = mem[rd_ptr % 1024];
  always @(posedge clk) begin
    if (get_tx_packet_data === 1'b1) rd_ptr <= rd_ptr + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: wire-level {dp,dm} per bit period for a whole packet.
  task automatic build_expected(input logic [2:0] code, input int n, input int base);
    logic [7:0]  pid;
    logic [7:0]  b;
    logic [15:0] r;
    logic [15:0] crc_tx;
    bit          bits [$];
    logic        lvl;
    int          ones;
    exp_q.delete();
    case (code)
      3'd1:    pid = 8'hC3;
      3'd2:    pid = 8'hD2;
      3'd3:    pid = 8'h5A;
      3'd4:    pid = 8'h1E;
      default: pid = 8'h00;
    endcase
    for (int i = 0; i < 7; i++) bits.push_back(1'b0);
    bits.push_back(1'b1);
    for (int i = 0; i < 8; i++) bits.push_back(pid[i]);
    if (code == 3'd1) begin
      // CRC-16/USB in reflected byte-wise form: poly 0xA001, init/xorout 0xFFFF.
      r = 16'hFFFF;
      for (int j = 0; j < n; j++) begin
        b = mem[(base + j) % 1024];
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        r = r ^ {8'h00, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      end
      crc_tx = ~r;
      for (int i = 0; i < 16; i++) bits.push_back(crc_tx[i]);
    end
    lvl = 1'b1;
    ones = 0;
    foreach (bits[i]) begin
      if (!bits[i]) lvl = ~lvl;
      exp_q.push_back({lvl, ~lvl});
      ones = bits[i] ? ones + 1 : 0;
      if (ones == 6) begin
        lvl = ~lvl;
        exp_q.push_back({lvl, ~lvl});
        ones = 0;
      end
    end
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
  endtask

  // One packet from request to idle; optional ACK intrusion while busy.
  task automatic run_packet(input logic [2:0] code, input logic [6:0] occ, input bit intrude);
    int n, base, k;
    n = (code == 3'd1) ? ((occ > 7'd64) ? 64 : int'(occ)) : 0;
    base = rd_ptr;
    build_expected(code, n, base);
    @(negedge clk);
    tx_packet = code;
    buffer_occupancy = occ;
    @(negedge clk);
    tx_packet = 3'd0;
    check("latency_active", tx_transfer_active, 1'b0);
    check("latency_line", {dp_out, dm_out}, 2'b10);
    k = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (tx_transfer_active !== 1'b1) break;
      if (k / 4 < exp_q.size()) check("line", {dp_out, dm_out}, exp_q[k / 4]);
      else check("line_overrun", k, 4 * exp_q.size());
      k++;
      if (intrude && k == 20) tx_packet = 3'd2;
      if (intrude && k == 40) tx_packet = 3'd0;
    end
    check("active_cycles", k, 4 * exp_q.size());
    check("strobes", rd_ptr - base, n);
    check("idle_line", {dp_out, dm_out}, 2'b10);
  endtask

  initial begin
    int base;
    n_rst = 1'b0;
    tx_packet = 3'd0;
    buffer_occupancy = 7'd0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dp", dp_out, 1'b1);
    check("rst_dm", dm_out, 1'b0);
    check("rst_active", tx_transfer_active, 1'b0);
    check("rst_get", get_tx_packet_data, 1'b0);
    check("rst_err", tx_error, 1'b0);
    n_rst = 1'b1;

    // ACK: 19 bit periods, no payload.
    run_packet(3'd2, 7'd5, 1'b0);
    check("ack_len", exp_q.size() * 4, 76);

    // Zero-length DATA0.
    run_packet(3'd1, 7'd0, 1'b0);
    check("zlp_len", exp_q.size() * 4, 140);

    // DATA0 FF,00: stuff bit inside the first byte.
    mem[rd_ptr % 1024] = 8'hFF;
    mem[(rd_ptr + 1) % 1024] = 8'h00;
    run_packet(3'd1, 7'd2, 1'b0);

    // Illegal request code.
    @(negedge clk);
    tx_packet = 3'd5;
    @(negedge clk);
    tx_packet = 3'd0;
    check("err_pulse", tx_error, 1'b1);
    check("err_line", {dp_out, dm_out}, 2'b10);
    check("err_active", tx_transfer_active, 1'b0);
    @(negedge clk);
    check("err_one_cycle", tx_error, 1'b0);
    check("err_no_start", tx_transfer_active, 1'b0);

    // ACK arriving during a DATA0 packet is ignored.
    run_packet(3'd1, 7'd3, 1'b1);

    // Reset mid-DATA after three strobes.
    base = rd_ptr;
    @(negedge clk);
    tx_packet = 3'd1;
    buffer_occupancy = 7'd10;
    @(negedge clk);
    tx_packet = 3'd0;
    for (int c = 0; c < 3000; c++) begin
      if (rd_ptr - base >= 3) break;
      @(negedge clk);
    end
    check("pops_before_reset", rd_ptr - base, 3);
    n_rst = 1'b0;
    @(negedge clk);
    check("midrst_line", {dp_out, dm_out}, 2'b10);
    check("midrst_active", tx_transfer_active, 1'b0);
    check("midrst_get", get_tx_packet_data, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (60) @(negedge clk);
    check("pops_after_reset", rd_ptr - base, 3);
    check("idle_after_reset", tx_transfer_active, 1'b0);
    run_packet(3'd3, 7'd0, 1'b0);

    // Randomized packets, including clamped occupancies.
    for (int i = 0; i < 8; i++) begin
      run_packet(3'($urandom_range(1, 4)), 7'($urandom_range(0, 127)), 1'b0);
    end
    run_packet(3'd1, 7'd100, 1'b0);
    run_packet(3'd4, 7'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
